fir_filter_param: RTL and testbench

FIR_FILTER_PARAM -- requirements
Module: fir_filter_param

---
 rtl/fir_filter_param.sv | 198 +++++++++++++++++++
 tb/tb_fir_filter_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_param.sv
// fir_filter_param
//   Two-stage pipelined FIR filter with runtime-writable coefficients,
//   rounding right-shift, unsigned saturation and a per-sample bypass.
//
//   Pipeline: a sample accepted in cycle t (in_valid=1) has its products
//   registered at the end of t. Sum/round/saturate is registered at the end
//   of t+1, so out_valid/out/sat are visible during cycle t+2. One sample per
//   cycle, no backpressure.
//
// Ports
//   CLK        in   1                 clock, rising edge
//   RST        in   1                 synchronous active-high reset
//   in_valid   in   1                 a carries a new sample
//   a          in   WIDTH             input sample (unsigned)
//   bypass     in   1                 this sample skips the filter
//   coef_we    in   1                 coefficient write strobe
//   coef_addr  in   max(1,clog2 TAPS) tap index (0 = newest sample)
//   coef_data  in   CW                coefficient value (unsigned)
//   out_valid  out  1                 one-cycle pulse per accepted sample
//   out        out  WIDTH             filtered (or bypassed) sample
//   sat        out  1                 result was clipped to 2^WIDTH-1
module fir_filter_param #(
    parameter int WIDTH = 8,
    parameter int TAPS  = 3,
    parameter int CW    = 8,
    parameter int SHIFT = 2
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic                                    in_valid,
    input  logic [WIDTH-1:0]                        a,
    input  logic                                    bypass,
    input  logic                                    coef_we,
    input  logic [((TAPS > 1) ? $clog2(TAPS) : 1)-1:0] coef_addr,
    input  logic [CW-1:0]                           coef_data,
    output logic                                    out_valid,
    output logic [WIDTH-1:0]                        out,
    output logic                                    sat
);

    localparam int AW    = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int LT    = $clog2(TAPS);
    localparam int PW    = WIDTH + CW;
    localparam int ACC_W = WIDTH + CW + LT;
    // One spare bit so adding the rounding constant can never wrap.
    localparam int RW    = ACC_W + 1;
    localparam int HN    = TAPS - 1;

    localparam logic [RW-1:0] RND   = (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic [AW:0]   TAPS_L = (AW + 1)'(TAPS);

    // Reset coefficient value: binomial C(n,k), built incrementally so every
    // intermediate division is exact.
    function automatic logic [CW-1:0] binom(input int n, input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) begin
            r = (r * (n - i)) / (i + 1);
        end
        return CW'(r);
    endfunction

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [CW-1:0]    coef_q [TAPS];
    logic [CW-1:0]    coef_d [TAPS];
    logic [WIDTH-1:0] hist_q [HN];
    logic [WIDTH-1:0] hist_d [HN];

    logic [PW-1:0]    prod_q [TAPS];
    logic [PW-1:0]    prod_d [TAPS];
    logic             v1_q;
    logic             byp1_q;
    logic [WIDTH-1:0] raw1_q;

    logic             v2_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             sat_q;
    logic             sat_d;

    // ---------------------------------------------------------------
    // Stage 0: sample window, products, history and coefficient update
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] win [TAPS];

    always_comb begin
        win[0] = a;
        for (int k = 1; k < TAPS; k++) begin
            win[k] = hist_q[k-1];
        end
    end

    // Products use the coefficients as they stand before this edge, so a
    // write in the same cycle only affects later samples.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            prod_d[k] = PW'(win[k]) * PW'(coef_q[k]);
        end
    end

    always_comb begin
        for (int i = 0; i < HN; i++) begin
            hist_d[i] = hist_q[i];
        end
        if (in_valid) begin
            hist_d[0] = a;
            for (int i = 1; i < HN; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            coef_d[k] = coef_q[k];
        end
        if (coef_we && ({1'b0, coef_addr} < TAPS_L)) begin
            coef_d[coef_addr] = coef_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= binom(TAPS - 1, k);
                prod_q[k] <= '0;
            end
            for (int i = 0; i < HN; i++) begin
                hist_q[i] <= '0;
            end
            v1_q   <= 1'b0;
            byp1_q <= 1'b0;
            raw1_q <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= coef_d[k];
            end
            for (int i = 0; i < HN; i++) begin
                hist_q[i] <= hist_d[i];
            end
            v1_q <= in_valid;
            if (in_valid) begin
                for (int k = 0; k < TAPS; k++) begin
                    prod_q[k] <= prod_d[k];
                end
                byp1_q <= bypass;
                raw1_q <= a;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 1 -> 2: sum, round, shift, saturate (or pass raw sample)
    // ---------------------------------------------------------------
    logic [ACC_W-1:0] acc;
    logic [RW-1:0]    rnd;
    logic [RW-1:0]    shifted;

    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + ACC_W'(prod_q[k]);
        end
        rnd     = {1'b0, acc} + RND;
        shifted = rnd >> SHIFT;

        out_d = shifted[WIDTH-1:0];
        sat_d = 1'b0;
        if (byp1_q) begin
            out_d = raw1_q;
        end else if (|shifted[RW-1:WIDTH]) begin
            out_d = {WIDTH{1'b1}};
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v2_q  <= 1'b0;
            out_q <= '0;
            sat_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
            // Outputs hold between valid pulses.
            if (v1_q) begin
                out_q <= out_d;
                sat_q <= sat_d;
            end
        end
    end

    assign out_valid = v2_q;
    assign out       = out_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_fir_filter_param.sv
module tb_fir_filter_param;

    logic       CLK;
    logic       RST;
    logic       in_valid;
    logic [7:0] a;
    logic       bypass;
    logic       coef_we;
    logic [1:0] coef_addr;
    logic [7:0] coef_data;
    logic       out_valid;
    logic [7:0] out;
    logic       sat;

    fir_filter_param #(.WIDTH(8), .TAPS(3), .CW(8), .SHIFT(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .a         (a),
        .bypass    (bypass),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out       (out),
        .sat       (sat)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int out;
        int sat;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc_m   = 0;

    // Reference model state: coefficients and the two previous samples.
    int coef_m [3];
    int hist_m [2];
    int last_out_m = 0;
    int last_sat_m = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_m);
    endtask

    task automatic model_reset();
        sbq.delete();
        coef_m = '{1, 2, 1};
        hist_m = '{0, 0};
        last_out_m = 0;
        last_sat_m = 0;
    endtask

    // Drive one cycle of inputs and update the model with what the DUT will
    // do at the coming rising edge.
    task automatic step(input logic rst, input logic v, input int av, input logic byp,
                        input logic we, input int addr, input int data);
        exp_t e;
        longint y;
        @(negedge CLK);
        RST       = rst;
        in_valid  = v;
        a         = 8'(av);
        bypass    = byp;
        coef_we   = we;
        coef_addr = 2'(addr);
        coef_data = 8'(data);
        if (rst) begin
            model_reset();
        end else begin
            if (v) begin
                y = longint'(coef_m[0]) * av + longint'(coef_m[1]) * hist_m[0]
                  + longint'(coef_m[2]) * hist_m[1];
                y = (y + 2) / 4;
                if (byp) begin
                    e.out = av;
                    e.sat = 0;
                end else if (y > 255) begin
                    e.out = 255;
                    e.sat = 1;
                end else begin
                    e.out = int'(y);
                    e.sat = 0;
                end
                e.cyc = cyc_m + 2;
                sbq.push_back(e);
                hist_m[1] = hist_m[0];
                hist_m[0] = av;
            end
            if (we && addr < 3) coef_m[addr] = data;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic feed(input int av, input logic byp);
        step(0, 1, av, byp, 0, 0, 0);
    endtask

    // Monitor: checks every cycle just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            cyc_m = cyc_m + 1;
            #1;
            if (out_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("spurious_valid", int'(out_valid), 0);
                end else begin
                    e = sbq.pop_front();
                    chk("latency", cyc_m, e.cyc);
                    chk("out", int'(out), e.out);
                    chk("sat", int'(sat), e.sat);
                    last_out_m = e.out;
                    last_sat_m = e.sat;
                end
            end else begin
                chk("hold_out", int'(out), last_out_m);
                chk("hold_sat", int'(sat), last_sat_m);
                if (sbq.size() > 0 && sbq[0].cyc <= cyc_m) begin
                    chk("missing_valid", int'(out_valid), 1);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        RST = 1'b1; in_valid = 1'b0; a = '0; bypass = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 99, 0, 1, 0, 77);   // reset overrides sample and write

        // Impulse
        feed(4, 0); feed(0, 0); feed(0, 0); feed(0, 0);
        idle(3);

        // Step
        for (int i = 0; i < 5; i++) feed(200, 0);
        idle(3);

        // Saturation with coef[0]=8
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 8);
        for (int i = 0; i < 5; i++) feed(255, 0);
        idle(3);

        // Bubbles
        step(1, 0, 0, 0, 0, 0, 0);
        feed(4, 0); idle(3); feed(0, 0); feed(0, 0);
        idle(3);

        // Reset with two samples in flight
        feed(100, 0); feed(120, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        feed(8, 0);
        idle(3);

        // Bypass then filtered; mixed in flight
        step(1, 0, 0, 0, 0, 0, 0);
        feed(37, 1); feed(0, 0);
        feed(250, 1); feed(250, 0); feed(9, 1); feed(60, 0);
        idle(3);

        // Out-of-range address ignored; same-cycle write uses old coefs
        step(0, 1, 40, 0, 1, 3, 200);
        step(0, 1, 40, 0, 1, 2, 50);
        feed(40, 0); feed(40, 0);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 255)),
                 ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 255)));
        end
        idle(5);
        chk("queue_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
